// File: rtl/pip_scaler_pingpong_if.sv
// Stream, configuration, raster and status signals of pip_scaler_pingpong.
// The scaler is the slave; whoever feeds pixels and raster timing is the master.
interface pip_scaler_pingpong_if #(
  parameter int unsigned PIX_W = 10
);
  logic               in_sof;
  logic               in_valid;
  logic [PIX_W-1:0]   in_r, in_g, in_b;
  logic [10:0]        cfg_dst_w, cfg_dst_h;
  logic [9:0]         cfg_x0, cfg_y0;
  logic               cfg_border_en;
  logic [3*PIX_W-1:0] cfg_border_rgb;
  logic [9:0]         vga_x, vga_y;
  logic               video_on;
  logic               frame_start;
  logic               out_valid;
  logic [PIX_W-1:0]   out_r, out_g, out_b;
  logic               rd_bank;
  logic               frame_ready;
  logic [7:0]         drop_cnt;

  modport master (
    output in_sof, in_valid, in_r, in_g, in_b, cfg_dst_w, cfg_dst_h, cfg_x0, cfg_y0,
           cfg_border_en, cfg_border_rgb, vga_x, vga_y, video_on, frame_start,
    input  out_valid, out_r, out_g, out_b, rd_bank, frame_ready, drop_cnt
  );

  modport slave (
    input  in_sof, in_valid, in_r, in_g, in_b, cfg_dst_w, cfg_dst_h, cfg_x0, cfg_y0,
           cfg_border_en, cfg_border_rgb, vga_x, vga_y, video_on, frame_start,
    output out_valid, out_r, out_g, out_b, rd_bank, frame_ready, drop_cnt
  );
endinterface

// File: rtl/pip_scaler_pingpong.sv
// Nearest-neighbour DDA downscaler into a ping-pong frame store, read out as a PiP window.
// Optional border ring is built only when PIP_SCALER_BORDER_EN is defined.
module pip_scaler_pingpong #(
  parameter int unsigned SRC_W     = 640,
  parameter int unsigned SRC_H     = 480,
  parameter int unsigned MAX_DST_W = 320,
  parameter int unsigned MAX_DST_H = 240,
  parameter int unsigned PIX_W     = 10,
  parameter int unsigned BORDER_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pip_scaler_pingpong_if.slave io
);
  localparam int unsigned SXW   = $clog2(SRC_W + 1);
  localparam int unsigned SYW   = $clog2(SRC_H + 1);
  localparam int unsigned AXW   = $clog2(2 * SRC_W);
  localparam int unsigned AYW   = $clog2(2 * SRC_H);
  localparam int unsigned DWW   = $clog2(MAX_DST_W + 1);
  localparam int unsigned DHW   = $clog2(MAX_DST_H + 1);
  localparam int unsigned PLANE = MAX_DST_W * MAX_DST_H;
  localparam int unsigned DEPTH = 2 * PLANE;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned RGBW  = 3 * PIX_W;

  function automatic logic [DWW-1:0] clamp_w(input logic [10:0] v);
    if (v == 11'd0) return DWW'(1);
    if (32'(v) > MAX_DST_W) return DWW'(MAX_DST_W);
    return DWW'(v);
  endfunction

  function automatic logic [DHW-1:0] clamp_h(input logic [10:0] v);
    if (v == 11'd0) return DHW'(1);
    if (32'(v) > MAX_DST_H) return DHW'(MAX_DST_H);
    return DHW'(v);
  endfunction

  function automatic logic [AW-1:0] buf_addr(input logic bank, input logic [AW-1:0] row,
                                             input logic [AW-1:0] col);
    return (bank ? AW'(PLANE) : '0) + row * AW'(MAX_DST_W) + col;
  endfunction

  logic [SXW-1:0]  sx_q, sx_c;
  logic [SYW-1:0]  sy_q, sy_c;
  logic [AXW-1:0]  acc_x_q, acc_x_c, sum_x;
  logic [AYW-1:0]  acc_y_q, acc_y_c, sum_y;
  logic [DWW-1:0]  wx_q, wx_c, cur_w_q, w_eff;
  logic [DHW-1:0]  wy_q, wy_c, cur_h_q, h_eff;
  logic [DWW-1:0]  wbw_q [2];
  logic [DHW-1:0]  wbh_q [2];
  logic            armed_q, wr_bank_q, rd_bank_q, done_bank_q, pending_q, frame_ready_q;
  logic [7:0]      drop_cnt_q;
  logic            swap, rd_bank_d, wr_bank_d, pend_sw, drop;
  logic            pix_ok, keep_x, keep_y, line_end, frame_end, we;
  logic [AW-1:0]   waddr;

  always_comb begin
    swap      = io.frame_start && pending_q;
    rd_bank_d = swap ? done_bank_q : rd_bank_q;
    pend_sw   = pending_q && !swap;
    wr_bank_d = io.in_sof ? ~rd_bank_d : wr_bank_q;
    drop      = io.in_sof && pend_sw && (done_bank_q == wr_bank_d);
    w_eff     = io.in_sof ? clamp_w(io.cfg_dst_w) : cur_w_q;
    h_eff     = io.in_sof ? clamp_h(io.cfg_dst_h) : cur_h_q;
    sx_c      = io.in_sof ? '0 : sx_q;
    sy_c      = io.in_sof ? '0 : sy_q;
    acc_x_c   = io.in_sof ? '0 : acc_x_q;
    acc_y_c   = io.in_sof ? '0 : acc_y_q;
    wx_c      = io.in_sof ? '0 : wx_q;
    wy_c      = io.in_sof ? '0 : wy_q;
    pix_ok    = io.in_valid && (io.in_sof || armed_q);
    sum_x     = acc_x_c + AXW'(w_eff);
    sum_y     = acc_y_c + AYW'(h_eff);
    keep_x    = sum_x >= AXW'(SRC_W);
    // A line is kept when the vertical accumulator would wrap at its end.
    keep_y    = sum_y >= AYW'(SRC_H);
    line_end  = sx_c == SXW'(SRC_W - 1);
    frame_end = line_end && (sy_c == SYW'(SRC_H - 1));
    we        = pix_ok && keep_x && keep_y;
    waddr     = buf_addr(wr_bank_d, AW'(wy_c), AW'(wx_c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q <= '0; sy_q <= '0; acc_x_q <= '0; acc_y_q <= '0; wx_q <= '0; wy_q <= '0;
      cur_w_q <= '0; cur_h_q <= '0; armed_q <= 1'b0;
      wr_bank_q <= 1'b0; rd_bank_q <= 1'b0; done_bank_q <= 1'b0; pending_q <= 1'b0;
      frame_ready_q <= 1'b0; drop_cnt_q <= '0;
      // Size registers start at full size so the blank pre-swap window is visible.
      wbw_q[0] <= DWW'(MAX_DST_W); wbw_q[1] <= DWW'(MAX_DST_W);
      wbh_q[0] <= DHW'(MAX_DST_H); wbh_q[1] <= DHW'(MAX_DST_H);
    end else begin
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      pending_q <= pend_sw && !drop;
      if (swap) frame_ready_q <= 1'b1;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (io.in_sof) begin
        armed_q <= 1'b1; cur_w_q <= w_eff; cur_h_q <= h_eff;
        wbw_q[wr_bank_d] <= w_eff; wbh_q[wr_bank_d] <= h_eff;
        sx_q <= '0; sy_q <= '0; acc_x_q <= '0; acc_y_q <= '0; wx_q <= '0; wy_q <= '0;
      end
      if (pix_ok) begin
        if (keep_x) begin
          acc_x_q <= sum_x - AXW'(SRC_W);
          wx_q    <= wx_c + 1'b1;
        end else begin
          acc_x_q <= sum_x;
        end
        if (line_end) begin
          sx_q <= '0; sy_q <= sy_c + 1'b1; acc_x_q <= '0; wx_q <= '0;
          if (keep_y) begin
            acc_y_q <= sum_y - AYW'(SRC_H);
            wy_q    <= wy_c + 1'b1;
          end else begin
            acc_y_q <= sum_y;
          end
          if (frame_end) begin
            armed_q <= 1'b0; pending_q <= 1'b1; done_bank_q <= wr_bank_d;
          end
        end else begin
          sx_q <= sx_c + 1'b1;
        end
      end
    end
  end

  // Stage p0: window hit and buffer address from the raster position.
  logic [9:0]      x0_q, y0_q, x0_e, y0_e, win_x, win_y;
  logic [11:0]     vx, vy;
  logic [DWW-1:0]  rbw;
  logic [DHW-1:0]  rbh;
  logic            hit, rdy_e, bord;
  logic [AW-1:0]   raddr, raddr_p1;
  logic [RGBW-1:0] brgb, rdata_p2, rgb_o;
  logic            vld_p1, vld_p2, rdy_p1, rdy_p2, bord_p1, bord_p2;
  logic [RGBW-1:0] mem_q [DEPTH];

  always_comb begin
    x0_e  = io.frame_start ? io.cfg_x0 : x0_q;
    y0_e  = io.frame_start ? io.cfg_y0 : y0_q;
    rdy_e = frame_ready_q || swap;
    rbw   = wbw_q[rd_bank_d];
    rbh   = wbh_q[rd_bank_d];
    vx    = {2'b00, io.vga_x};
    vy    = {2'b00, io.vga_y};
    win_x = io.vga_x - x0_e;
    win_y = io.vga_y - y0_e;
    hit   = io.video_on && (vx >= 12'(x0_e)) && (vx < 12'(x0_e) + 12'(rbw)) &&
            (vy >= 12'(y0_e)) && (vy < 12'(y0_e) + 12'(rbh));
    raddr = buf_addr(rd_bank_d, AW'(win_y), AW'(win_x));
  end

`ifdef PIP_SCALER_BORDER_EN
  logic            ben_q;
  logic [RGBW-1:0] brgb_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ben_q <= 1'b0; brgb_q <= '0;
    end else if (io.frame_start) begin
      ben_q <= io.cfg_border_en; brgb_q <= io.cfg_border_rgb;
    end
  end
  assign bord = (io.frame_start ? io.cfg_border_en : ben_q) &&
                ((32'(win_x) < BORDER_W) || (32'(win_x) + BORDER_W >= 32'(rbw)) ||
                 (32'(win_y) < BORDER_W) || (32'(win_y) + BORDER_W >= 32'(rbh)));
  assign brgb = brgb_q;
`else
  logic unused_border;
  assign unused_border = ^{io.cfg_border_en, io.cfg_border_rgb, BORDER_W};
  assign bord = 1'b0;
  assign brgb = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0; y0_q <= '0;
      vld_p1 <= 1'b0; vld_p2 <= 1'b0; rdy_p1 <= 1'b0; rdy_p2 <= 1'b0;
      bord_p1 <= 1'b0; bord_p2 <= 1'b0;
    end else begin
      x0_q <= x0_e; y0_q <= y0_e;
      vld_p1 <= hit; rdy_p1 <= rdy_e; bord_p1 <= bord;
      vld_p2 <= vld_p1; rdy_p2 <= rdy_p1; bord_p2 <= bord_p1;
    end
  end

  // Stage p1 -> p2: synchronous buffer read; single write port from the scaler.
  always_ff @(posedge clk) begin
    raddr_p1 <= raddr;
    if (we) mem_q[waddr] <= {io.in_r, io.in_g, io.in_b};
    rdata_p2 <= mem_q[raddr_p1];
  end

  assign rgb_o          = !vld_p2 ? '0 : bord_p2 ? brgb : rdy_p2 ? rdata_p2 : '0;
  assign io.out_valid   = vld_p2;
  assign io.out_r       = rgb_o[3*PIX_W-1:2*PIX_W];
  assign io.out_g       = rgb_o[2*PIX_W-1:PIX_W];
  assign io.out_b       = rgb_o[PIX_W-1:0];
  assign io.rd_bank     = rd_bank_q;
  assign io.frame_ready = frame_ready_q;
  assign io.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_pip_scaler_pingpong.sv
// Bench for pip_scaler_pingpong at reduced frame sizes against a frame-level reference model.
module tb_pip_scaler_pingpong;
  localparam int SW = 16, SH = 12, MW = 8, MH = 6, PW = 10, PXW = 3 * PW;
  localparam int RW = 24, RH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pip_scaler_pingpong_if #(.PIX_W(PW)) io ();

  pip_scaler_pingpong #(
    .SRC_W(SW), .SRC_H(SH), .MAX_DST_W(MW), .MAX_DST_H(MH), .PIX_W(PW), .BORDER_W(2)
  ) dut (
    .clk(clk), .rst(rst), .io(io)
  );

  int total = 0, bad = 0;

  logic [PXW-1:0] frm [SH][SW];
  logic [PXW-1:0] bank_img [2][SH][SW];
  int bank_w [2], bank_h [2];
  int m_rd, m_pend, m_done, m_ready, m_drop, m_wr, x0m, y0m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampd(input int v, input int mx);
    if (v < 1) return 1;
    if (v > mx) return mx;
    return v;
  endfunction

  // Source index of the k-th kept sample when S samples are reduced to d.
  function automatic int srcidx(input int k, input int s, input int d);
    return ((k + 1) * s + d - 1) / d - 1;
  endfunction

  task automatic model_reset();
    m_rd = 0; m_pend = 0; m_done = 0; m_ready = 0; m_drop = 0; m_wr = 0; x0m = 0; y0m = 0;
    bank_w[0] = MW; bank_w[1] = MW; bank_h[0] = MH; bank_h[1] = MH;
  endtask

  task automatic model_fs(input int fx, input int fy);
    if (m_pend != 0) begin
      m_rd = m_done; m_pend = 0; m_ready = 1;
    end
    x0m = fx; y0m = fy;
  endtask

  task automatic model_sof(input int cw, input int ch);
    m_wr = 1 - m_rd;
    if (m_pend != 0 && m_done == m_wr) begin
      m_pend = 0;
      if (m_drop < 255) m_drop++;
    end
    bank_w[m_wr] = clampd(cw, MW);
    bank_h[m_wr] = clampd(ch, MH);
  endtask

  task automatic model_done();
    m_pend = 1; m_done = m_wr;
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++) bank_img[m_wr][y][x] = frm[y][x];
  endtask

  task automatic exp_pix(input int x, input int y, input bit on,
                         output logic [31:0] ev, output logic [31:0] er);
    int w, h;
    w = bank_w[m_rd]; h = bank_h[m_rd];
    ev = 0; er = 0;
    if (on && x >= x0m && x < x0m + w && y >= y0m && y < y0m + h) begin
      ev = 1;
      if (m_ready != 0)
        er = 32'(bank_img[m_rd][srcidx(y - y0m, SH, h)][srcidx(x - x0m, SW, w)]);
    end
  endtask

  task automatic chk_status();
    chk("rd_bank", 32'(io.rd_bank), 32'(m_rd));
    chk("frame_ready", 32'(io.frame_ready), 32'(m_ready));
    chk("drop_cnt", 32'(io.drop_cnt), 32'(m_drop));
  endtask

  task automatic send_frame(input int cw, input int ch, input int nl, input bit grad,
                            input bit fs_first, input int fx, input int fy);
    logic [PXW-1:0] pix;
    io.cfg_dst_w = 11'(cw); io.cfg_dst_h = 11'(ch);
    io.video_on = 1'b0;
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < SW; x++) begin
        while ($urandom_range(0, 4) == 0) begin
          io.in_valid = 1'b0; io.in_sof = 1'b0;
          tick();
        end
        pix = grad ? {3{PW'(x)}} : PXW'($urandom);
        frm[y][x] = pix;
        io.in_valid = 1'b1;
        io.in_sof = (x == 0 && y == 0);
        {io.in_r, io.in_g, io.in_b} = pix;
        if (x == 0 && y == 0) begin
          if (fs_first) begin
            io.frame_start = 1'b1; io.cfg_x0 = 10'(fx); io.cfg_y0 = 10'(fy);
            io.vga_x = '0; io.vga_y = '0;
            model_fs(fx, fy);
          end
          model_sof(cw, ch);
        end
        tick();
        io.in_sof = 1'b0; io.frame_start = 1'b0;
      end
    end
    io.in_valid = 1'b0;
    if (nl == SH) model_done();
  endtask

  task automatic scan(input int fx, input int fy);
    logic [31:0] qv [$];
    logic [31:0] qr [$];
    logic [31:0] ev, er;
    bit on;
    for (int i = 0; i <= RW * RH; i++) begin
      if (i < RW * RH) begin
        on = ($urandom_range(0, 7) != 0);
        io.vga_x = 10'(i % RW); io.vga_y = 10'(i / RW); io.video_on = on;
        io.frame_start = (i == 0);
        if (i == 0) begin
          io.cfg_x0 = 10'(fx); io.cfg_y0 = 10'(fy);
          model_fs(fx, fy);
        end
        exp_pix(i % RW, i / RW, on, ev, er);
        qv.push_back(ev); qr.push_back(er);
      end else begin
        io.video_on = 1'b0;
      end
      tick();
      io.frame_start = 1'b0;
      if (i >= 1) begin
        ev = qv.pop_front(); er = qr.pop_front();
        chk("out_valid", 32'(io.out_valid), ev);
        chk("out_rgb", 32'({io.out_r, io.out_g, io.out_b}), er);
      end
    end
    io.video_on = 1'b0;
  endtask

  int nf;

  initial begin
    rst = 1'b1;
    io.in_sof = 0; io.in_valid = 0; io.in_r = 0; io.in_g = 0; io.in_b = 0;
    io.cfg_dst_w = 11'd8; io.cfg_dst_h = 11'd6; io.cfg_x0 = 0; io.cfg_y0 = 0;
    io.cfg_border_en = 0; io.cfg_border_rgb = '0;
    io.vga_x = 0; io.vga_y = 0; io.video_on = 0; io.frame_start = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_out_valid", 32'(io.out_valid), 0);
    chk("rst_out_rgb", 32'({io.out_r, io.out_g, io.out_b}), 0);
    chk_status();
    rst = 1'b0;
    tick();

    // Blank full-size window before any frame has been swapped in.
    scan(3, 2);
    chk_status();

    // Half-size gradient frame: kept column k is source pixel 2k+1.
    send_frame(8, 6, SH, 1'b1, 1'b0, 0, 0);
    chk_status();
    scan(8, 4);
    chk_status();
    for (int k = 0; k < MW; k++) begin
      io.vga_x = 10'(8 + k); io.vga_y = 10'd5; io.video_on = 1'b1;
      tick(); tick();
      chk("grad_valid", 32'(io.out_valid), 1);
      chk("grad_r", 32'(io.out_r), 32'(2 * k + 1));
    end
    io.video_on = 1'b0;

    // Non-integer ratio.
    send_frame(5, 3, SH, 1'b0, 1'b0, 0, 0);
    scan(11, 7);
    chk_status();

    // Clamping of out-of-range sizes.
    send_frame(0, 1000, SH, 1'b0, 1'b0, 0, 0);
    scan(4, 3);
    send_frame(1000, 0, SH, 1'b0, 1'b0, 0, 0);
    scan(2, 9);
    chk_status();

    // Three frames without a display swap: two drops.
    for (int f = 0; f < 3; f++) send_frame(7, 5, SH, 1'b0, 1'b0, 0, 0);
    chk_status();
    scan(6, 6);
    chk_status();

    // Source start and display swap in the same cycle with a frame pending.
    send_frame(6, 4, SH, 1'b0, 1'b0, 0, 0);
    send_frame(8, 6, SH, 1'b0, 1'b1, 1, 1);
    chk_status();
    scan(1, 1);
    chk_status();

    // Reset in the middle of a frame, then a clean frame.
    send_frame(8, 6, 5, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    tick();
    model_reset();
    chk("midrst_out_valid", 32'(io.out_valid), 0);
    chk("midrst_out_rgb", 32'({io.out_r, io.out_g, io.out_b}), 0);
    chk_status();
    rst = 1'b0;
    tick();
    send_frame(4, 6, SH, 1'b0, 1'b0, 0, 0);
    scan(0, 0);
    chk_status();

    // Randomized sizes, positions and frame counts.
    for (int it = 0; it < 4; it++) begin
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++)
        send_frame($urandom_range(0, 12), $urandom_range(0, 9), SH, 1'b0, 1'b0, 0, 0);
      chk_status();
      scan($urandom_range(0, RW - MW), $urandom_range(0, RH - MH));
      chk_status();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
